// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router input-port logic.
//   PORTS / DEST_W      : number of output ports and width of the destination field
//   DEST_LSB / DEST_MSB : where the destination sits inside a flit
//   state_t             : requester FSM states
//   onehot()            : destination index -> one-hot request vector
package router_pkg;

  localparam int PORTS    = 4;
  localparam int DEST_W   = 2;
  localparam int DEST_LSB = 0;
  localparam int DEST_MSB = DEST_LSB + DEST_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic logic [PORTS-1:0] onehot(input logic [DEST_W-1:0] dest);
    onehot       = '0;
    onehot[dest] = 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, pop  : write/read strobes; push when full and pop when empty are ignored
//   din        : write data
//   head       : entry at the read pointer (valid when !empty)
//   next_head  : the entry that will be at the head after this cycle's push/pop
//   count      : occupancy, $clog2(DEPTH)+1 bits
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          head,
  output logic [DATA_W-1:0]          next_head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              push_ok;
  logic              pop_ok;
  logic [AW-1:0]     rd_adv;
  logic [CW-1:0]     remain;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr];

  // Lookahead lets the requester register req for the flit that will be at
  // the head next cycle, including a flit being pushed into an emptying FIFO.
  assign rd_adv    = rd_ptr + AW'(pop_ok);
  assign remain    = count_q - CW'(pop_ok);
  assign next_head = (remain != '0) ? mem[rd_adv] : din;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/input_request_port.sv
// input_request_port: requester side of output-port arbitration for one
// router input port. Buffers single-flit packets, raises a one-hot request
// toward the destination arbiter, forwards the flit once granted.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : upstream flit valid
//   in_ready   : FIFO has room (count < DEPTH)
//   in_data    : upstream flit, bits [1:0] = destination port
//   req        : registered one-hot request, bit k -> output-port-k arbiter
//   grant      : grant bits from the arbiters
//   out_valid  : registered one-cycle strobe for the forwarded flit
//   out_data   : registered forwarded flit
//   starve     : high while waiting in REQ for STARVE_LIMIT cycles or more
//   grant_err  : one-cycle pulse after any grant bit outside req
module input_request_port
  import router_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [PORTS-1:0]  req,
  input  logic [PORTS-1:0]  grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              starve,
  output logic              grant_err
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  state_t            state;
  state_t            state_next;
  logic              push;
  logic              pop;
  logic              match;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] next_head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_d;
  logic [PORTS-1:0]  req_d;
  logic              out_valid_d;
  logic              starve_d;
  logic              grant_err_d;
  logic              unused_next_head;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == SEND);
  assign match    = |(grant & req);

  // Only the destination field of the lookahead head is needed here; the
  // payload is taken from the current head when entering SEND.
  assign unused_next_head = ^next_head[DATA_W-1:DEST_MSB+1];

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .din       (in_data),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. IDLE looks at the incoming push so req appears the
  // cycle after a push into an empty FIFO.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (!empty || push) state_next = REQ;
      REQ:  if (match)          state_next = SEND;
      SEND: state_next = ((count > CW'(1)) || push) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and wait counter.
  // The counter restarts on every entry to REQ because the prior state was
  // not REQ; it only counts REQ cycles that did not see a matching grant.
  always_comb begin
    req_d       = '0;
    out_valid_d = 1'b0;
    wait_d      = '0;
    if (state_next == REQ) req_d = onehot(next_head[DEST_MSB:DEST_LSB]);
    if (state_next == SEND) out_valid_d = 1'b1;
    if (state == REQ && !match)
      wait_d = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
    starve_d    = (state_next == REQ) && (wait_d >= WAIT_W'(STARVE_LIMIT));
    grant_err_d = |(grant & ~req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      wait_cnt  <= '0;
      starve    <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      req       <= req_d;
      out_valid <= out_valid_d;
      if (out_valid_d) out_data <= head;
      wait_cnt  <= wait_d;
      starve    <= starve_d;
      grant_err <= grant_err_d;
    end
  end

endmodule

// File: tb/tb_input_request_port.sv
// Testbench for input_request_port. Stimulus drives and samples on the
// falling edge; expected flits go into a queue that a separate monitor
// drains whenever out_valid is seen.
module tb_input_request_port;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [3:0]        req;
  logic [3:0]        grant = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              starve;
  logic              grant_err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;
  logic [3:0] rr_seq [7] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                             4'b1000, 4'b0000, 4'b0001};

  input_request_port #(
    .DATA_W       (DATA_W),
    .DEPTH        (4),
    .STARVE_LIMIT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .starve    (starve),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_flit(input logic [DATA_W-1:0] d, input bit accepted);
    in_valid = 1'b1;
    in_data  = d;
    if (accepted) exp_q.push_back(d);
  endtask

  // Monitor: every forwarded flit must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", out_data, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    tick(); tick();
    check("rst_req", {28'd0, req}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_starve", {31'd0, starve}, 32'd0);
    check("rst_grant_err", {31'd0, grant_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Single flit to port 2, grant one cycle after req rises
    push_flit(32'hCAFE_0012, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t1_req_rise", {28'd0, req}, 32'h4);
    tick();
    check("t1_req_hold", {28'd0, req}, 32'h4);
    grant = 4'b0100;
    tick();
    grant = 4'b0000;
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_req_send", {28'd0, req}, 32'd0);
    check("t1_no_err", {31'd0, grant_err}, 32'd0);
    tick();
    check("t1_out_valid_drop", {31'd0, out_valid}, 32'd0);
    check("t1_req_idle", {28'd0, req}, 32'd0);
    tick();

    // Fill to full with dest 0,1,3,0; 5th push ignored; immediate grants
    push_flit(32'h1000_0000, 1'b1); tick();
    push_flit(32'h2000_0001, 1'b1); tick();
    push_flit(32'h3000_0003, 1'b1); tick();
    push_flit(32'h4000_0000, 1'b1); tick();
    check("t2_full_ready", {31'd0, in_ready}, 32'd0);
    push_flit(32'h5000_0002, 1'b0); tick();
    in_valid = 1'b0;
    check("t2_still_full", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t2_rr_req%0d", i), {28'd0, req}, {28'd0, rr_seq[i]});
      grant = rr_seq[i];
      tick();
    end
    grant = 4'b0000;
    check("t2_last_send", {31'd0, out_valid}, 32'd1);
    tick();
    check("t2_idle_req", {28'd0, req}, 32'd0);
    check("t2_ready_again", {31'd0, in_ready}, 32'd1);
    tick();

    // Starvation on port 3
    push_flit(32'h7777_0003, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("t3_req_c%0d", k), {28'd0, req}, 32'h8);
      check($sformatf("t3_starve_c%0d", k), {31'd0, starve}, (k >= 16) ? 32'd1 : 32'd0);
      if (k == 20) grant = 4'b1000;
      tick();
    end
    grant = 4'b0000;
    check("t3_send_valid", {31'd0, out_valid}, 32'd1);
    check("t3_starve_clear", {31'd0, starve}, 32'd0);
    tick();
    tick();

    // Illegal grants while requesting port 1
    push_flit(32'h0BAD_0101, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t4_req", {28'd0, req}, 32'h2);
    grant = 4'b0001;
    tick();
    grant = 4'b0000;
    check("t4_err_pulse", {31'd0, grant_err}, 32'd1);
    check("t4_stay_req", {28'd0, req}, 32'h2);
    check("t4_no_send", {31'd0, out_valid}, 32'd0);
    tick();
    check("t4_err_clear", {31'd0, grant_err}, 32'd0);
    check("t4_still_req", {28'd0, req}, 32'h2);
    grant = 4'b0011;
    tick();
    grant = 4'b0000;
    check("t4_err_with_send", {31'd0, grant_err}, 32'd1);
    check("t4_send_valid", {31'd0, out_valid}, 32'd1);
    check("t4_send_req", {28'd0, req}, 32'd0);
    tick();
    check("t4_err_gone", {31'd0, grant_err}, 32'd0);
    tick();

    // Push during SEND while the last entry is being popped
    push_flit(32'hAAAA_0001, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t5_req_a", {28'd0, req}, 32'h2);
    grant = 4'b0010;
    tick();
    grant = 4'b0000;
    check("t5_send_a", {31'd0, out_valid}, 32'd1);
    push_flit(32'hCCCC_0003, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t5_req_c", {28'd0, req}, 32'h8);
    check("t5_gap", {31'd0, out_valid}, 32'd0);
    grant = 4'b1000;
    tick();
    grant = 4'b0000;
    check("t5_send_c", {31'd0, out_valid}, 32'd1);
    tick();
    check("t5_idle", {28'd0, req}, 32'd0);
    tick();

    // Reset mid-REQ with 3 entries queued
    push_flit(32'hD000_0002, 1'b1); tick();
    push_flit(32'hD100_0001, 1'b1); tick();
    push_flit(32'hD200_0000, 1'b1); tick();
    in_valid = 1'b0;
    check("t6_req_before", {28'd0, req}, 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check("t6_req_async", {28'd0, req}, 32'd0);
    check("t6_ready_async", {31'd0, in_ready}, 32'd1);
    check("t6_out_valid_async", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    grant = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_req_after%0d", i), {28'd0, req}, 32'd0);
    end
    grant = 4'b0000;
    tick();

    check("all_flits_delivered", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
